// File: rtl/adder_result_fifo_if.sv
// Result stream from adder_result_fifo to its consumer.
//   out_valid : FIFO holds at least one entry
//   out_ready : consumer takes the head entry this cycle
//   out_data  : head entry (don't-care while out_valid=0)
// master = FIFO side, slave = consumer side.
interface adder_result_fifo_if #(
    parameter int C_WIDTH = 7
);
    logic               out_valid;
    logic               out_ready;
    logic [C_WIDTH-1:0] out_data;

    modport master (output out_valid, output out_data, input out_ready);
    modport slave  (input out_valid, input out_data, output out_ready);
endinterface

// File: rtl/adder_result_fifo.sv
// adder_result_fifo
// Captures each valid adder result one cycle after the adder's valid strobe,
// buffers it in a DEPTH-entry circular FIFO and hands it to a consumer over
// a valid/ready stream. Also keeps a running sum of accepted results and a
// sticky flag for results dropped because the FIFO was full.
// Ports:
//   clk, reset  clock, asynchronous active-high reset
//   in_valid    valid strobe that drives the adder (result follows next cycle)
//   c           adder result
//   clear       synchronous clear of acc/overflow (FIFO untouched)
//   rd          result stream (master modport)
//   count       occupied entries
//   acc         modulo-2^ACC_WIDTH sum of accepted results
//   overflow    sticky: a result was dropped
module adder_result_fifo #(
    parameter int DEPTH     = 4,
    parameter int C_WIDTH   = 7,
    parameter int ACC_WIDTH = 12,
    localparam int CNT_W    = $clog2(DEPTH + 1),
    localparam int PTR_W    = $clog2(DEPTH)
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic                 in_valid,
    input  logic [C_WIDTH-1:0]   c,
    input  logic                 clear,
    adder_result_fifo_if.master  rd,
    output logic [CNT_W-1:0]     count,
    output logic [ACC_WIDTH-1:0] acc,
    output logic                 overflow
);
    localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DEPTH - 1);

    typedef enum logic [1:0] {S_EMPTY, S_PARTIAL, S_FULL} state_t;

    state_t             state, state_nxt;
    logic               cap_pend;
    logic [PTR_W-1:0]   wr_ptr, rd_ptr;
    logic [C_WIDTH-1:0] mem [DEPTH];
    logic               pop, push, drop;

    // out_ready only feeds the full check, never out_valid, so a push can
    // land in a full FIFO in the same cycle the head leaves.
    assign pop  = rd.out_valid && rd.out_ready;
    assign push = cap_pend && ((state != S_FULL) || pop);
    assign drop = cap_pend && (state == S_FULL) && !pop;

    assign rd.out_data = mem[rd_ptr];

    // c is only meaningful the cycle after in_valid was sampled.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) cap_pend <= 1'b0;
        else       cap_pend <= in_valid;
    end

    always_ff @(posedge clk) begin
        if (push) mem[wr_ptr] <= c;
    end

    // DEPTH is a power of two, so pointer wrap is natural overflow.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (push) wr_ptr <= PTR_W'(wr_ptr + 1'b1);
            if (pop)  rd_ptr <= PTR_W'(rd_ptr + 1'b1);
            if (push && !pop)      count <= CNT_W'(count + 1'b1);
            else if (pop && !push) count <= CNT_W'(count - 1'b1);
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) state <= S_EMPTY;
        else       state <= state_nxt;
    end

    always_comb begin
        state_nxt    = state;
        rd.out_valid = (state != S_EMPTY);
        case (state)
            S_EMPTY:   if (push) state_nxt = S_PARTIAL;
            S_PARTIAL: begin
                if (push && !pop && count == CNT_LAST)     state_nxt = S_FULL;
                else if (pop && !push && count == CNT_ONE) state_nxt = S_EMPTY;
            end
            S_FULL:    if (pop && !push) state_nxt = S_PARTIAL;
            default:   state_nxt = S_EMPTY;
        endcase
    end

    // Clear and a same-cycle accepted push: the sum restarts at that result.
    // A dropped push sets overflow even while clear is asserted.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            acc      <= '0;
            overflow <= 1'b0;
        end else begin
            if (clear)     acc <= push ? ACC_WIDTH'(c) : '0;
            else if (push) acc <= ACC_WIDTH'(acc + ACC_WIDTH'(c));
            if (drop)       overflow <= 1'b1;
            else if (clear) overflow <= 1'b0;
        end
    end
endmodule

// File: tb/tb_adder_result_fifo.sv
module tb_adder_result_fifo;
    localparam int DEPTH = 4, C_WIDTH = 7, ACC_WIDTH = 8;
    localparam int CNT_W = $clog2(DEPTH + 1);

    logic                 clk = 1'b0;
    logic                 reset, in_valid, clear;
    logic [5:0]           a, b;
    logic [C_WIDTH-1:0]   c;
    logic [CNT_W-1:0]     count;
    logic [ACC_WIDTH-1:0] acc;
    logic                 overflow;
    int                   n_vec = 0, n_err = 0;

    adder_result_fifo_if #(.C_WIDTH(C_WIDTH)) rd_if ();

    adder_result_fifo #(.DEPTH(DEPTH), .C_WIDTH(C_WIDTH), .ACC_WIDTH(ACC_WIDTH)) dut (
        .clk(clk), .reset(reset), .in_valid(in_valid), .c(c), .clear(clear),
        .rd(rd_if), .count(count), .acc(acc), .overflow(overflow)
    );

    always #5 clk = ~clk;

    // Stand-in for the upstream adder: one-cycle registered a+b.
    always_ff @(posedge clk or posedge reset) begin
        if (reset)         c <= '0;
        else if (in_valid) c <= {1'b0, a} + {1'b0, b};
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_vec++;
        assert (got === exp) else begin
            n_err++;
            $display("FAIL %s: observed %0d expected %0d", tag, got, exp);
            $error("%s observed %0d expected %0d", tag, got, exp);
        end
    endtask

    initial begin
        int exp_drain [4] = '{4, 6, 8, 14};
        reset = 1'b1; in_valid = 1'b0; clear = 1'b0; a = '0; b = '0;
        rd_if.out_ready = 1'b0;
        tick();
        chk("rst_count", count, 0);
        chk("rst_valid", rd_if.out_valid, 0);
        chk("rst_acc", acc, 0);
        chk("rst_ovf", overflow, 0);
        reset = 1'b0;

        // single result 3+4
        a = 3; b = 4; in_valid = 1'b1; rd_if.out_ready = 1'b1;
        tick();
        in_valid = 1'b0;
        chk("t1_valid_e1", rd_if.out_valid, 0);
        tick();
        chk("t1_valid_e2", rd_if.out_valid, 1);
        chk("t1_data", rd_if.out_data, 7);
        chk("t1_count1", count, 1);
        chk("t1_acc", acc, 7);
        tick();
        chk("t1_count0", count, 0);
        chk("t1_valid_e3", rd_if.out_valid, 0);

        // clear alone
        clear = 1'b1; tick(); clear = 1'b0;
        chk("clr_acc", acc, 0);

        // fill with 2,4,6,8 then drop 10
        rd_if.out_ready = 1'b0;
        for (int i = 1; i <= 5; i++) begin
            a = 6'(i); b = 6'(i); in_valid = 1'b1;
            tick();
        end
        in_valid = 1'b0;
        chk("fill_count", count, 4);
        chk("fill_ovf_pre", overflow, 0);
        tick();
        chk("ovf_count", count, 4);
        chk("ovf_set", overflow, 1);
        chk("ovf_acc", acc, 20);
        chk("ovf_head", rd_if.out_data, 2);

        // clear leaves FIFO contents intact
        clear = 1'b1; tick(); clear = 1'b0;
        chk("clr2_ovf", overflow, 0);
        chk("clr2_acc", acc, 0);
        chk("clr2_count", count, 4);

        // push+pop while full
        a = 7; b = 7; in_valid = 1'b1;
        tick();
        in_valid = 1'b0; rd_if.out_ready = 1'b1;
        tick();
        chk("pp_count", count, 4);
        chk("pp_ovf", overflow, 0);
        chk("pp_acc", acc, 14);
        for (int k = 0; k < 4; k++) begin
            chk("drain_valid", rd_if.out_valid, 1);
            chk("drain_data", rd_if.out_data, exp_drain[k]);
            tick();
        end
        chk("drain_empty", rd_if.out_valid, 0);
        chk("drain_count", count, 0);

        // accumulator wrap: 9 x 30 = 270 -> 14 mod 256
        reset = 1'b1; tick(); reset = 1'b0;
        a = 15; b = 15;
        for (int i = 0; i < 9; i++) begin
            in_valid = 1'b1;
            tick();
        end
        in_valid = 1'b0;
        tick(); tick();
        chk("wrap_acc", acc, 14);
        chk("wrap_count", count, 0);
        a = 1; b = 2; in_valid = 1'b1;
        tick();
        in_valid = 1'b0; clear = 1'b1;
        tick();
        clear = 1'b0;
        chk("clrpush_acc", acc, 3);
        chk("clrpush_ovf", overflow, 0);
        chk("clrpush_data", rd_if.out_data, 3);
        tick();

        // drop coinciding with clear: overflow wins, acc cleared
        rd_if.out_ready = 1'b0;
        for (int i = 1; i <= 5; i++) begin
            a = 6'(i); b = 6'(i); in_valid = 1'b1;
            tick();
        end
        in_valid = 1'b0; clear = 1'b1;
        tick();
        clear = 1'b0;
        chk("clrdrop_ovf", overflow, 1);
        chk("clrdrop_acc", acc, 0);
        chk("clrdrop_count", count, 4);

        // reset mid-stream: 3 buffered plus one pending capture
        reset = 1'b1; tick(); reset = 1'b0;
        for (int i = 1; i <= 4; i++) begin
            a = 6'(i); b = 6'(i); in_valid = 1'b1;
            tick();
        end
        in_valid = 1'b0;
        chk("mid_count", count, 3);
        reset = 1'b1;
        #1;
        chk("mid_rst_valid", rd_if.out_valid, 0);
        chk("mid_rst_count", count, 0);
        chk("mid_rst_acc", acc, 0);
        tick();
        reset = 1'b0;
        tick();
        chk("mid_nostray", count, 0);
        rd_if.out_ready = 1'b1;
        a = 2; b = 5; in_valid = 1'b1;
        tick();
        in_valid = 1'b0;
        tick();
        chk("post_valid", rd_if.out_valid, 1);
        chk("post_data", rd_if.out_data, 7);
        chk("post_count", count, 1);
        tick();
        chk("post_empty", count, 0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end
endmodule

// File: doc/adder_result_fifo.md
# adder_result_fifo

Downstream stage of the `adder` block. It tracks the adder's one-cycle result latency and captures each valid `c` into a small FIFO. It presents the captured results to the consumer through a valid/ready handshake. It also keeps a running sum, a fill count and a sticky overflow flag for results it had to drop.

## Interface
- `DEPTH`, 4, FIFO entries; power of two, at least 2.
- `C_WIDTH`, 7, width of the adder result `c`.
- `ACC_WIDTH`, 12, width of the running accumulator.
- `clk`  input  1  clock; reset reset, asynchronous, active-high; clock clk.
- `reset`  input  1  asynchronous active-high reset.
- `in_valid`  input  1  the same `valid` strobe that drives the adder.
- `c`  input  C_WIDTH  adder result output.
- `clear`  input  1  synchronous clear of `acc` and `overflow`; FIFO contents are untouched.
- `out_valid`  output  1  FIFO is not empty.
- `out_ready`  input  1  consumer accepts the head entry.
- `out_data`  output  C_WIDTH  head entry of the FIFO.
- `count`  output  $clog2(DEPTH+1)  number of occupied entries.
- `acc`  output  ACC_WIDTH  sum of all accepted results since reset or `clear`.
- `overflow`  output  1  sticky; set when a result is dropped.

## Operation
- Capture stage:
  - `cap_pend` is a register loaded with `in_valid` every cycle.
  - When `cap_pend`=1, `c` carries the adder's registered `a+b`, and a push is requested with data `c`.
- Push/pop:
  - pop = `out_valid` && `out_ready`.
  - push is accepted when `count` < DEPTH, or when a pop happens in the same cycle.
  - Push while full with no pop: the result is dropped, `overflow` is set to 1, and `acc` is unchanged.
- FIFO:
  - Storage is a circular buffer with `wr_ptr`/`rd_ptr` of log2(DEPTH) bits; both wrap DEPTH-1 to 0.
  - `count` changes by +1 on push only, -1 on pop only, and is unchanged on push+pop.
  - `out_data` is driven combinationally from the entry at `rd_ptr`. It is don't-care while `out_valid`=0.
- Accumulator:
  - `acc` <= `acc` + zero-extended `c` on every accepted push.
  - Arithmetic is modulo 2^ACC_WIDTH; wrap is silent.
- Clear:
  - `clear`=1 alone: `acc`<=0, `overflow`<=0.
  - `clear` with an accepted push in the same cycle: `acc`<=`c`.
  - `clear` with a dropped push in the same cycle: `overflow`<=1, because set wins over clear.
- State machine, derived from `count`:
  - EMPTY (`count`=0), PARTIAL, FULL (`count`=DEPTH).
  - EMPTY->PARTIAL on push.
  - PARTIAL->FULL on push without pop when `count`=DEPTH-1.
  - FULL->PARTIAL on pop without push.
  - PARTIAL->EMPTY on pop without push when `count`=1.
- Pop while empty cannot occur, because pop is gated by `out_valid`.
- Reset is asynchronous and clears all state:
  - `cap_pend`=0, pointers=0, `count`=0, `out_valid`=0, `acc`=0, `overflow`=0.
  - Storage contents are not reset.
  - A reset mid-stream discards any pending capture and all buffered entries.

## Timing
- `in_valid` sampled at edge N -> adder updates `c` at edge N -> push at edge N+1.
- `out_valid`=1 and `out_data` valid from edge N+1 (two edges after the operands were presented).
- Back-to-back `in_valid` yields one push per cycle.
- A handshake completes at the edge where `out_valid`&&`out_ready`=1. The next entry is presented in the following cycle.
- `count`, `acc` and `overflow` update at the same edge as the push or pop that causes them.
- No combinational path from `out_ready` to `out_valid`. `out_ready` gates the full-check combinationally, which is what allows push+pop when full.

## Test plan
- Single result: reset, then `a`=3, `b`=4, `in_valid` for 1 cycle, `out_ready`=1 -> after 2 edges `out_valid`=1 and `out_data`=7 for one cycle; `count` 0->1->0; `acc`=7.
- Fill/overflow: `out_ready`=0, 5 consecutive valids with (1,1),(2,2),(3,3),(4,4),(5,5) -> `count`=4, `overflow`=1, `acc`=20; draining yields 2,4,6,8 and the 10 is never output.
- Push+pop at full: FIFO holding 2,4,6,8, then a valid with (7,7) and `out_ready`=1 on the push edge -> 2 is popped, 14 is accepted, `count` stays 4, `overflow` stays 0, and the drain order is 4,6,8,14.
- Accumulator wrap and clear: `ACC_WIDTH`=8, 9 pushes of (15,15) with `out_ready`=1 -> `acc`=270 mod 256=14. Then assert `clear` together with a push of (1,2) -> `acc`=3, `overflow`=0.
- Reset mid-operation: 3 entries buffered plus a pending capture, assert `reset` for 1 cycle -> `out_valid`=0, `count`=0, `acc`=0, and no stray push follows. The next single valid (2,5) is output as 7.
